// File: rtl/flash_cpu_pkg.sv
// Shared definitions for the flash-executing CPU: instruction-word fields,
// opcode values and the encodings of the core and handshake state machines.
package flash_cpu_pkg;

  localparam int IMM_BIT = 15;
  localparam int OPC_MSB = 14;
  localparam int OPC_LSB = 9;
  localparam int IDX_MSB = 3;
  localparam int IDX_LSB = 0;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_CLR  = 6'd0;
  localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OPC_W-1:0] OP_STA  = 6'd2;
  localparam logic [OPC_W-1:0] OP_INV  = 6'd3;
  localparam logic [OPC_W-1:0] OP_SUB  = 6'd4;
  localparam logic [OPC_W-1:0] OP_JMPZ = 6'd5;
  localparam logic [OPC_W-1:0] OP_WAIT = 6'd6;
  localparam logic [OPC_W-1:0] OP_HLT  = 6'd7;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'd8;
  localparam logic [OPC_W-1:0] OP_BTN  = 6'd9;
  localparam logic [OPC_W-1:0] OP_LED  = 6'd10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_F_WS,
    S_F_WD,
    S_DECODE,
    S_RETRIEVE,
    S_R_WS,
    S_R_WD,
    S_EXECUTE,
    S_WAIT,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT_FALL,
    HS_WAIT_RISE
  } hs_phase_t;

endpackage

// File: rtl/flash_read_hs.sv
// Flash reader handshake: raise the request, wait for ready to fall, then
// for ready to rise (data valid), then drop the request. Shared by fetch and retrieve.
module flash_read_hs
  import flash_cpu_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic ready_i,
  output logic en_o,
  output logic fell_o,
  output logic done_o
);

  hs_phase_t phase_q, phase_d;
  logic      en_q, en_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    phase_d = phase_q;
    en_d    = en_q;
    fell_o  = 1'b0;
    done_o  = 1'b0;
    unique case (phase_q)
      HS_IDLE: begin
        if (start_i) begin
          phase_d = HS_WAIT_FALL;
          en_d    = 1'b1;
        end
      end
      HS_WAIT_FALL: begin
        // A ready that is still high from the previous read must not count as data valid.
        if (!ready_i) begin
          phase_d = HS_WAIT_RISE;
          fell_o  = 1'b1;
        end
      end
      HS_WAIT_RISE: begin
        if (ready_i) begin
          phase_d = HS_IDLE;
          en_d    = 1'b0;
          done_o  = 1'b1;
        end
      end
      default: phase_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      phase_q <= HS_IDLE;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      en_q    <= en_d;
    end
  end

  assign en_o = en_q;

endmodule

// File: rtl/flash_cpu_core.sv
// Flash-executing CPU core: fetches 16-bit words through the shared reader
// handshake, executes them on a small register file and drives LEDs/wait/buttons.
module flash_cpu_core
  import flash_cpu_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int NREGS      = 4,
  parameter int PC_W       = 11,
  parameter int ADDR_W     = 24,
  parameter int NBTN       = 4,
  parameter int NLEDS      = 6,
  parameter int WAIT_TICKS = 27000
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_en,
  input  logic [15:0]       flash_data,
  input  logic              flash_ready,
  input  logic [NBTN-1:0]   btn_n,
  output logic [NLEDS-1:0]  leds,
  output logic              halted,
  output logic [PC_W-1:0]   pc_dbg
);

  localparam int RIDX_W = $clog2(NREGS);
  localparam int CNT_W  = DATA_W + $clog2(WAIT_TICKS + 1);
  localparam logic [CNT_W-1:0] TICKS = CNT_W'(WAIT_TICKS);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         cmd_q;
  logic [15:0]         imm_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [NLEDS-1:0]    leds_q, leds_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;

  logic                hs_start, hs_fell, hs_done;
  logic                imm_f;
  logic [OPC_W-1:0]    opc;
  logic [3:0]          idx;
  logic [RIDX_W-1:0]   ridx;
  logic [DATA_W-1:0]   p;
  logic [PC_W-1:0]     jmp_tgt;
  logic [15:0]         btn_ext;
  logic                unused_bits;

  flash_read_hs u_hs (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (hs_start),
    .ready_i (flash_ready),
    .en_o    (flash_en),
    .fell_o  (hs_fell),
    .done_o  (hs_done)
  );

  assign imm_f   = cmd_q[IMM_BIT];
  assign opc     = cmd_q[OPC_MSB:OPC_LSB];
  assign idx     = cmd_q[IDX_MSB:IDX_LSB];
  assign ridx    = RIDX_W'(int'(idx) % NREGS);
  assign p       = imm_f ? imm_q[DATA_W-1:0] : regs_q[ridx];
  assign btn_ext = 16'(btn_n);

  // Immediate jump targets come from the raw flash word, so a PC wider than
  // DATA_W can still reach the whole address range.
  assign jmp_tgt = imm_f ? PC_W'(imm_q) : PC_W'(regs_q[ridx]);

  assign unused_bits = ^{cmd_q[8:4], imm_q};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    regs_d   = regs_q;
    leds_d   = leds_q;
    wcnt_d   = wcnt_q;
    hs_start = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        hs_start = 1'b1;
        state_d  = S_F_WS;
      end
      S_F_WS:  if (hs_fell) state_d = S_F_WD;
      S_F_WD:  if (hs_done) state_d = S_DECODE;
      S_DECODE: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = imm_f ? S_RETRIEVE : S_EXECUTE;
      end
      S_RETRIEVE: begin
        hs_start = 1'b1;
        state_d  = S_R_WS;
      end
      S_R_WS:  if (hs_fell) state_d = S_R_WD;
      S_R_WD: begin
        if (hs_done) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opc)
          OP_CLR:  regs_d[ridx] = '0;
          OP_ADD:  regs_d[0]    = regs_q[0] + p;
          OP_STA:  regs_d[ridx] = regs_q[0];
          OP_INV:  regs_d[ridx] = ~regs_q[ridx];
          OP_SUB:  regs_d[0]    = regs_q[0] - p;
          OP_JMPZ: if (regs_q[0] == '0) pc_d = jmp_tgt;
          OP_WAIT: begin
            wcnt_d  = CNT_W'(p) * TICKS;
            state_d = S_WAIT;
          end
          OP_HLT:  state_d = S_HALT;
          OP_JMP:  pc_d = jmp_tgt;
          OP_BTN:  regs_d[0] = DATA_W'((int'(idx) < NBTN) && !btn_ext[idx]);
          OP_LED:  leds_d = ~regs_q[0][NLEDS-1:0];
          default: ;
        endcase
      end
      S_WAIT: begin
        // Terminal count is checked before decrementing, giving p*WAIT_TICKS+1 cycles here.
        if (wcnt_q == '0) state_d = S_FETCH;
        else              wcnt_d  = wcnt_q - CNT_W'(1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      cmd_q   <= '0;
      imm_q   <= '0;
      leds_q  <= '1;
      wcnt_q  <= '0;
      // NOTE: the register file is tiny and architecturally defined as zero after reset, so it is reset like any flop.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      leds_q  <= leds_d;
      wcnt_q  <= wcnt_d;
      regs_q  <= regs_d;
      if (state_q == S_F_WD && hs_done) cmd_q <= flash_data;
      if (state_q == S_R_WD && hs_done) imm_q <= flash_data;
    end
  end

  assign flash_addr = ADDR_W'(pc_q);
  assign leds       = leds_q;
  assign halted     = (state_q == S_HALT);
  assign pc_dbg     = pc_q;

endmodule
